alu_mc: RTL and testbench
=========================

ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/result width; legal range 4..32.
REQ-002 SHALL have one clock and an asynchronous, active-high reset: clk  input  1  rising-edge clock; reset  input  1  async active-high reset.
REQ-003 start  input  1  request; accepted only when busy=0.
REQ-004 op_alu  input  4  operation code (REQ-010).
REQ-005 s_inm  input  1  operand-swap select for 0011/0111.
REQ-006 interruption  input  1  flag-bank select, sampled with start.
REQ-007 a, b  input  WIDTH  operands, sampled with start.
REQ-008 y  output  WIDTH  registered result; busy  output  1  operation in flight; done  output  1  one-cycle completion pulse.
REQ-009 carry, overflow, zero  output  1 each  normal flag bank; carry_intr, overflow_intr, zero_intr  output  1 each  interrupt flag bank.

Function
REQ-010 SHALL implement: 0000 a; 0001 ~a; 0010 a+b; 0011 s_inm ? b-a : a-b; 0100 a&b; 0101 a|b; 0110 -a; 0111 s_inm ? -a : -b; 1000 a<<sh; 1001 a>>sh logical; 1010 a>>>sh arithmetic; 1011 a*b low WIDTH bits, unsigned; 1100-1111 reserved; sh = b[clog2(WIDTH)-1:0].
REQ-011 SHALL latch a, b, op_alu, s_inm, interruption on the accepting edge; later input changes SHALL NOT affect the operation.
REQ-012 SHALL use FSM states IDLE, MUL, DONE; IDLE+start+op=1011 -> MUL; IDLE+start+other op -> DONE; MUL after WIDTH iteration cycles -> DONE; DONE -> IDLE unconditionally.
REQ-013 MUL SHALL be shift-and-add, one multiplier bit per cycle, 2*WIDTH-bit accumulator.
REQ-014 Latency: done SHALL be high in the cycle after acceptance for non-MUL ops and WIDTH+1 cycles after acceptance for MUL.
REQ-015 done SHALL be high exactly one cycle per accepted op; y and the selected flag bank SHALL update on the edge entering DONE and hold until the next done.
REQ-016 busy SHALL be high from the cycle after acceptance through the done cycle inclusive; start while busy=1 SHALL be ignored, no queuing.
REQ-017 interruption=0 SHALL update only the normal bank; =1 only the interrupt bank; the other bank SHALL hold.
REQ-018 carry: add = carry-out of bit WIDTH-1; sub = borrow (minuend < subtrahend unsigned); shifts = last bit shifted out, 0 when sh=0; MUL = upper half nonzero; others 0.
REQ-019 overflow: add/sub = signed two's-complement overflow; 0110/0111 = negated operand is 1 followed by zeros; MUL = upper half nonzero; others 0.
REQ-020 zero SHALL be 1 iff the WIDTH-bit result is 0, for all non-reserved ops.
REQ-021 Reserved ops SHALL produce y=0, leave both flag banks unchanged, complete with non-MUL latency.
REQ-022 Arithmetic SHALL wrap modulo 2^WIDTH; no x/z on any output after reset.

Reset
REQ-023 reset=1 SHALL immediately force state IDLE, y=0, busy=0, done=0, all six flags 0, independent of clk.
REQ-024 reset asserted during MUL or DONE SHALL abort the operation with no done pulse; first start after release SHALL be accepted normally.

Verification (WIDTH=16)
REQ-025 start, op=0010, a=0x7FFF, b=0x0001, intr=0 -> next cycle done=1, y=0x8000, overflow=1, carry=0, zero=0; interrupt bank unchanged.
REQ-026 start, op=0011, s_inm=1, a=0x0005, b=0x0003 -> y=0xFFFE, carry=1, overflow=0; op=0110, a=0x8000 -> y=0x8000, overflow=1.
REQ-027 start, op=1011, a=0x0100, b=0x0100 -> busy 17 cycles, done at cycle 17, y=0x0000, carry=1, overflow=1, zero=1; start pulses while busy ignored.
REQ-028 start, op=0010, a=0xFFFF, b=0x0001, intr=1 -> carry_intr=1, zero_intr=1, overflow_intr=0; normal bank holds prior values.
REQ-029 start, op=1010, a=0x8001, b=0x0001 -> y=0xC000, carry=1; op=1000, b=0x0000 -> y=a, carry=0.
REQ-030 reset pulse at cycle 8 of a MUL -> all outputs 0 immediately, no done; next op=0000, a=0x1234 completes with y=0x1234.

Source files
------------

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arith/shift ops, serial shift-and-add multiply,
// with two selectable flag banks (normal / interrupt).
module alu_mc #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [3:0]       op_alu,
   input  logic             s_inm,
   input  logic             interruption,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] y,
   output logic             busy,
   output logic             done,
   output logic             carry,
   output logic             overflow,
   output logic             zero,
   output logic             carry_intr,
   output logic             overflow_intr,
   output logic             zero_intr
);

   localparam int SW = $clog2(WIDTH);
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   y_q, y_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic [2:0]         nflags_q, nflags_d;
   logic [2:0]         iflags_q, iflags_d;
   logic               intr_q, intr_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [2*WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0]   mplier_q, mplier_d;
   logic [CW-1:0]      cnt_q, cnt_d;

   logic [WIDTH-1:0]   res, mn, sbt, neg_src;
   logic               res_c, res_v, rsv;
   logic [WIDTH:0]     sum, diff, shl, shr;
   logic signed [WIDTH:0] sra_s;
   logic [SW-1:0]      sh;
   logic [2*WIDTH-1:0] acc_nxt;
   logic               mul_hi;
   logic               upd, fsel;
   logic [2:0]         fl;

   // Single-cycle datapath; shifts use one guard bit so the last bit shifted out lands there.
   always_comb begin
      sh      = b[SW-1:0];
      mn      = s_inm ? b : a;
      sbt     = s_inm ? a : b;
      neg_src = (op_alu == 4'b0111 && !s_inm) ? b : a;
      sum     = {1'b0, a} + {1'b0, b};
      diff    = {1'b0, mn} - {1'b0, sbt};
      shl     = {1'b0, a} << sh;
      shr     = {a, 1'b0} >> sh;
      sra_s   = $signed({a, 1'b0}) >>> sh;
      res     = '0;
      res_c   = 1'b0;
      res_v   = 1'b0;
      rsv     = 1'b0;
      case (op_alu)
         4'b0000: res = a;
         4'b0001: res = ~a;
         4'b0010: begin
            res   = sum[WIDTH-1:0];
            res_c = sum[WIDTH];
            res_v = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
         end
         4'b0011: begin
            res   = diff[WIDTH-1:0];
            res_c = diff[WIDTH];
            res_v = (mn[WIDTH-1] != sbt[WIDTH-1]) && (diff[WIDTH-1] != mn[WIDTH-1]);
         end
         4'b0100: res = a & b;
         4'b0101: res = a | b;
         4'b0110, 4'b0111: begin
            res   = '0 - neg_src;
            res_v = (neg_src == {1'b1, {(WIDTH-1){1'b0}}});
         end
         4'b1000: begin
            res   = shl[WIDTH-1:0];
            res_c = shl[WIDTH];
         end
         4'b1001: begin
            res   = shr[WIDTH:1];
            res_c = shr[0];
         end
         4'b1010: begin
            res   = sra_s[WIDTH:1];
            res_c = sra_s[0];
         end
         4'b1011: res = '0;
         default: rsv = 1'b1;
      endcase
   end

   always_comb begin
      acc_nxt = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
      mul_hi  = |acc_nxt[2*WIDTH-1:WIDTH];
   end

   always_comb begin
      state_d  = state_q;
      y_d      = y_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      nflags_d = nflags_q;
      iflags_d = iflags_q;
      intr_d   = intr_q;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      cnt_d    = cnt_q;
      upd      = 1'b0;
      fsel     = intr_q;
      fl       = '0;
      case (state_q)
         IDLE: begin
            busy_d = 1'b0;
            if (start) begin
               busy_d = 1'b1;
               intr_d = interruption;
               if (op_alu == 4'b1011) begin
                  state_d  = MUL;
                  acc_d    = '0;
                  mcand_d  = {{WIDTH{1'b0}}, a};
                  mplier_d = b;
                  cnt_d    = '0;
               end else begin
                  state_d = DONE;
                  done_d  = 1'b1;
                  y_d     = res;
                  upd     = !rsv;
                  fsel    = interruption;
                  fl      = {res_c, res_v, (res == '0)};
               end
            end
         end
         MUL: begin
            acc_d    = acc_nxt;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
               state_d = DONE;
               done_d  = 1'b1;
               y_d     = acc_nxt[WIDTH-1:0];
               upd     = 1'b1;
               fl      = {mul_hi, mul_hi, (acc_nxt[WIDTH-1:0] == '0)};
            end
         end
         DONE: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
      if (upd) begin
         if (fsel) iflags_d = fl;
         else      nflags_d = fl;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         y_q      <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         nflags_q <= '0;
         iflags_q <= '0;
         intr_q   <= 1'b0;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         y_q      <= y_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         nflags_q <= nflags_d;
         iflags_q <= iflags_d;
         intr_q   <= intr_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         cnt_q    <= cnt_d;
      end
   end

   assign y             = y_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign carry         = nflags_q[2];
   assign overflow      = nflags_q[1];
   assign zero          = nflags_q[0];
   assign carry_intr    = iflags_q[2];
   assign overflow_intr = iflags_q[1];
   assign zero_intr     = iflags_q[0];

endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc (WIDTH=16): directed vectors push expected results,
// a done-triggered monitor pops and compares result, both flag banks and latency.
module tb_alu_mc;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [3:0]  op_alu;
   logic        s_inm;
   logic        interruption;
   logic [15:0] a, b;
   logic [15:0] y;
   logic        busy, done;
   logic        carry, overflow, zero, carry_intr, overflow_intr, zero_intr;

   alu_mc #(.WIDTH(16)) dut (
      .clk(clk), .reset(reset), .start(start), .op_alu(op_alu), .s_inm(s_inm),
      .interruption(interruption), .a(a), .b(b), .y(y), .busy(busy), .done(done),
      .carry(carry), .overflow(overflow), .zero(zero), .carry_intr(carry_intr),
      .overflow_intr(overflow_intr), .zero_intr(zero_intr)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] y;
      logic [5:0]  f;
      int          done_at;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   logic [2:0] nb, ib;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (!reset && done) begin
         if (sb.size() == 0) begin
            chk("unexpected_done", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("y", {16'h0, y}, {16'h0, e.y});
            chk("flags", {26'h0, carry, overflow, zero, carry_intr, overflow_intr, zero_intr},
                {26'h0, e.f});
            chk("done_cycle", cyc, e.done_at);
         end
      end
   end

   task automatic issue(input logic [3:0] op, input logic s, input logic in,
                        input logic [15:0] av, input logic [15:0] bv,
                        input logic [15:0] ey, input logic [2:0] ef);
      exp_t e;
      int   t;
      t = 0;
      @(negedge clk);
      while (busy && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (t >= 200) chk("idle_timeout", 32'd1, 32'd0);
      op_alu = op; s_inm = s; interruption = in; a = av; b = bv; start = 1'b1;
      if (op < 4'd12) begin
         if (in) ib = ef;
         else    nb = ef;
      end
      e.y       = ey;
      e.f       = {nb, ib};
      e.done_at = cyc + 1 + ((op == 4'b1011) ? 16 : 0);
      sb.push_back(e);
      @(negedge clk);
      start = 1'b0;
      chk("busy_after_accept", {31'h0, busy}, 32'd1);
   endtask

   initial begin
      int n;
      reset = 1'b1; start = 1'b0; op_alu = '0; s_inm = 1'b0; interruption = 1'b0;
      a = '0; b = '0; nb = '0; ib = '0;
      repeat (2) @(negedge clk);
      chk("rst_y", {16'h0, y}, 32'd0);
      chk("rst_ctl", {30'h0, busy, done}, 32'd0);
      chk("rst_flags", {26'h0, carry, overflow, zero, carry_intr, overflow_intr, zero_intr}, 32'd0);
      reset = 1'b0;

      issue(4'b0010, 1'b0, 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 3'b010);
      issue(4'b0011, 1'b1, 1'b0, 16'h0005, 16'h0003, 16'hFFFE, 3'b100);
      issue(4'b0110, 1'b0, 1'b0, 16'h8000, 16'h0000, 16'h8000, 3'b010);

      // MUL with start pulses and operand changes while busy; both must be ignored.
      issue(4'b1011, 1'b0, 1'b0, 16'h0100, 16'h0100, 16'h0000, 3'b111);
      n = 1;
      for (int k = 0; k < 40 && busy; k++) begin
         if (k >= 1 && k <= 4) begin
            start = 1'b1; op_alu = 4'b0000; a = 16'hAAAA; b = 16'h5555;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         if (busy) n++;
      end
      start = 1'b0;
      chk("mul_busy_cycles", n, 32'd17);

      issue(4'b0010, 1'b0, 1'b1, 16'hFFFF, 16'h0001, 16'h0000, 3'b101);
      issue(4'b1010, 1'b0, 1'b0, 16'h8001, 16'h0001, 16'hC000, 3'b100);
      issue(4'b1000, 1'b0, 1'b0, 16'h1234, 16'h0000, 16'h1234, 3'b000);
      issue(4'b1100, 1'b0, 1'b0, 16'h0005, 16'h0005, 16'h0000, 3'b000);
      issue(4'b0001, 1'b0, 1'b0, 16'h00FF, 16'h0000, 16'hFF00, 3'b000);
      issue(4'b0100, 1'b0, 1'b0, 16'hF0F0, 16'h0FF0, 16'h00F0, 3'b000);
      issue(4'b0101, 1'b0, 1'b0, 16'hF000, 16'h000F, 16'hF00F, 3'b000);
      issue(4'b0111, 1'b0, 1'b0, 16'h0001, 16'h8000, 16'h8000, 3'b010);
      issue(4'b1001, 1'b0, 1'b0, 16'h800F, 16'h0004, 16'h0800, 3'b100);
      issue(4'b0011, 1'b0, 1'b0, 16'h8000, 16'h0001, 16'h7FFF, 3'b010);
      issue(4'b0000, 1'b0, 1'b0, 16'h0000, 16'h1111, 16'h0000, 3'b001);
      issue(4'b1011, 1'b0, 1'b1, 16'h0003, 16'h0005, 16'h000F, 3'b000);
      issue(4'b1011, 1'b0, 1'b0, 16'hFFFF, 16'h0002, 16'hFFFE, 3'b110);

      // Abort a MUL mid-flight with an asynchronous reset between clock edges.
      issue(4'b1011, 1'b0, 1'b0, 16'h0100, 16'h0100, 16'h0000, 3'b111);
      repeat (7) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      chk("abort_y", {16'h0, y}, 32'd0);
      chk("abort_ctl", {30'h0, busy, done}, 32'd0);
      chk("abort_flags", {26'h0, carry, overflow, zero, carry_intr, overflow_intr, zero_intr}, 32'd0);
      sb.delete();
      nb = '0; ib = '0;
      @(negedge clk);
      reset = 1'b0;
      repeat (20) @(negedge clk);
      issue(4'b0000, 1'b0, 1'b0, 16'h1234, 16'h0000, 16'h1234, 3'b000);

      for (int t = 0; t < 100 && sb.size() != 0; t++) @(negedge clk);
      chk("scoreboard_drained", sb.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
